// File: rtl/cpu_regfile_pkg.sv
// Shared types and select-decoding helpers for the CPU register file.
package cpu_regfile_pkg;

    localparam int NIBBLE = 4;

    // Register / operand selects used by the microcode sequencer.
    typedef enum logic [4:0] {
        REG_A, REG_B, REG_TEMP,
        REG_XL, REG_XH, REG_XP,
        REG_YL, REG_YH, REG_YP,
        REG_SPL, REG_SPH,
        REG_MX, REG_MY, REG_MSP, REG_Mn,
        REG_IMM_ADDR_L, REG_IMM_ADDR_H, REG_IMM_ADDR_P,
        REG_IMML, REG_IMMH, REG_HARDCODED_1,
        REG_ALU, REG_FLAGS,
        REG_PCSL, REG_PCSH, REG_PCP, REG_PCB, REG_NPP, REG_NBP
    } reg_type;

    // Index registers that can be post-incremented (or SP decremented).
    typedef enum logic [1:0] {
        REG_NONE, REG_XHL, REG_YHL, REG_SP
    } reg_inc_type;

    // Two-bit r/q field of an instruction mapped to its operand.
    function automatic reg_type imm_addressed_reg(input logic [1:0] code);
        case (code)
            2'b00:   return REG_A;
            2'b01:   return REG_B;
            2'b10:   return REG_MX;
            default: return REG_MY;
        endcase
    endfunction

    // Resolve immediate-addressed selects; everything else passes through.
    function automatic reg_type resolve_reg(input reg_type sel, input logic [5:0] immed);
        case (sel)
            REG_IMM_ADDR_L: return imm_addressed_reg(immed[1:0]);
            REG_IMM_ADDR_H: return imm_addressed_reg(immed[3:2]);
            REG_IMM_ADDR_P: return imm_addressed_reg(immed[5:4]);
            default:        return sel;
        endcase
    endfunction

    function automatic logic is_mem_reg(input reg_type sel);
        return (sel == REG_MX) || (sel == REG_MY) || (sel == REG_MSP) || (sel == REG_Mn);
    endfunction

    // Selects backed by a flop nibble in this block.
    function automatic logic is_reg_writable(input reg_type sel);
        case (sel)
            REG_A, REG_B, REG_XL, REG_XH, REG_XP,
            REG_YL, REG_YH, REG_YP, REG_SPL, REG_SPH: return 1'b1;
            default:                                  return 1'b0;
        endcase
    endfunction

    // Selects this block can service (expects an already resolved select).
    function automatic logic is_supported(input reg_type sel);
        return is_reg_writable(sel) || is_mem_reg(sel) ||
               (sel == REG_IMML) || (sel == REG_IMMH) || (sel == REG_HARDCODED_1);
    endfunction

endpackage

// File: rtl/cpu_regfile_index_counter.sv
// Wrapping +/-1 on a {hi,lo} nibble pair, used for X, Y and SP updates.
module index_counter #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] lo,
    input  logic             dec,
    output logic [WIDTH-1:0] next_hi,
    output logic [WIDTH-1:0] next_lo
);

    localparam logic [2*WIDTH-1:0] ONE = {{(2*WIDTH-1){1'b0}}, 1'b1};

    logic [2*WIDTH-1:0] result;

    // Modulo 2^(2*WIDTH) step; carry/borrow out of the pair is dropped.
    always_comb begin
        result = dec ? ({hi, lo} - ONE) : ({hi, lo} + ONE);
    end

    assign {next_hi, next_lo} = result;

endmodule

// File: rtl/cpu_regfile.sv
// Register file and index-register unit: A, B, X, Y, SP plus operand routing
// to the data-memory port.
module cpu_regfile
    import cpu_regfile_pkg::*;
#(
    parameter int DATA_WIDTH = NIBBLE,
    parameter bit BYPASS     = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  reg_type                 rd_sel,
    input  logic [5:0]              rd_immed,
    output logic [DATA_WIDTH-1:0]   rd_data,
    input  logic                    wr_en,
    input  reg_type                 wr_sel,
    input  logic [5:0]              wr_immed,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic                    inc_en,
    input  reg_inc_type             inc_sel,
    input  logic                    sp_dec,
    output logic [3*DATA_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    output logic                    mem_we,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [3*DATA_WIDTH-1:0] x_out,
    output logic [3*DATA_WIDTH-1:0] y_out,
    output logic [2*DATA_WIDTH-1:0] sp_out,
    output logic                    sel_err
);

    localparam int W = DATA_WIDTH;

    logic [W-1:0] a_q, b_q, xl_q, xh_q, xp_q, yl_q, yh_q, yp_q, spl_q, sph_q;
    logic [W-1:0] a_n, b_n, xl_n, xh_n, xp_n, yl_n, yh_n, yp_n, spl_n, sph_n;
    logic [W-1:0] x_inc_hi, x_inc_lo, y_inc_hi, y_inc_lo, sp_inc_hi, sp_inc_lo;
    logic [W-1:0] rd_reg;
    logic [3*W-1:0] rd_addr, wr_addr;
    logic sel_err_q, sel_err_n;
    logic wr_mem;
    reg_type rd_res, wr_res;

    assign rd_res = resolve_reg(rd_sel, rd_immed);
    assign wr_res = resolve_reg(wr_sel, wr_immed);

    // Data-memory address an operand select points at (0 for non-memory selects).
    function automatic logic [3*W-1:0] addr_of(input reg_type sel, input logic [5:0] immed);
        logic [3*W-1:0] addr;
        addr = '0;
        case (sel)
            REG_MX:  addr = {xp_q, xh_q, xl_q};
            REG_MY:  addr = {yp_q, yh_q, yl_q};
            REG_MSP: addr = {{W{1'b0}}, sph_q, spl_q};
            REG_Mn:  addr[3:0] = immed[3:0];
            default: addr = '0;
        endcase
        return addr;
    endfunction

    index_counter #(.WIDTH(W)) u_x_cnt (
        .hi(xh_q), .lo(xl_q), .dec(1'b0), .next_hi(x_inc_hi), .next_lo(x_inc_lo)
    );
    index_counter #(.WIDTH(W)) u_y_cnt (
        .hi(yh_q), .lo(yl_q), .dec(1'b0), .next_hi(y_inc_hi), .next_lo(y_inc_lo)
    );
    index_counter #(.WIDTH(W)) u_sp_cnt (
        .hi(sph_q), .lo(spl_q), .dec(sp_dec), .next_hi(sp_inc_hi), .next_lo(sp_inc_lo)
    );

    // Memory port: a write-side memory operand wins the shared address bus.
    always_comb begin
        rd_addr   = addr_of(rd_res, rd_immed);
        wr_addr   = addr_of(wr_res, wr_immed);
        wr_mem    = wr_en && is_mem_reg(wr_res);
        mem_we    = wr_mem;
        mem_wdata = wr_data;
        mem_addr  = wr_mem ? wr_addr : rd_addr;
    end

    // Read mux with optional same-cycle forwarding of the write port.
    always_comb begin
        // NOTE: every combinational output gets a default before the case, so
        // unlisted selects cannot infer a latch.
        rd_reg = '0;
        case (rd_res)
            REG_A:           rd_reg = a_q;
            REG_B:           rd_reg = b_q;
            REG_XL:          rd_reg = xl_q;
            REG_XH:          rd_reg = xh_q;
            REG_XP:          rd_reg = xp_q;
            REG_YL:          rd_reg = yl_q;
            REG_YH:          rd_reg = yh_q;
            REG_YP:          rd_reg = yp_q;
            REG_SPL:         rd_reg = spl_q;
            REG_SPH:         rd_reg = sph_q;
            REG_IMML:        rd_reg = W'(rd_immed[3:0]);
            REG_IMMH:        rd_reg = W'(rd_immed[5:4]);
            REG_HARDCODED_1: rd_reg = W'(1);
            REG_MX, REG_MY, REG_MSP, REG_Mn: rd_reg = mem_rdata;
            default:         rd_reg = '0;
        endcase
        if (BYPASS && wr_en && (rd_res == wr_res) && is_reg_writable(wr_res))
            rd_data = wr_data;
        else
            rd_data = rd_reg;
    end

    // Next register state: increment first, then the write overrides one nibble.
    always_comb begin
        {a_n, b_n, xl_n, xh_n, xp_n} = {a_q, b_q, xl_q, xh_q, xp_q};
        {yl_n, yh_n, yp_n, spl_n, sph_n} = {yl_q, yh_q, yp_q, spl_q, sph_q};
        if (inc_en) begin
            case (inc_sel)
                REG_XHL: {xh_n, xl_n}   = {x_inc_hi, x_inc_lo};
                REG_YHL: {yh_n, yl_n}   = {y_inc_hi, y_inc_lo};
                REG_SP:  {sph_n, spl_n} = {sp_inc_hi, sp_inc_lo};
                default: ;
            endcase
        end
        if (wr_en) begin
            case (wr_res)
                REG_A:   a_n   = wr_data;
                REG_B:   b_n   = wr_data;
                REG_XL:  xl_n  = wr_data;
                REG_XH:  xh_n  = wr_data;
                REG_XP:  xp_n  = wr_data;
                REG_YL:  yl_n  = wr_data;
                REG_YH:  yh_n  = wr_data;
                REG_YP:  yp_n  = wr_data;
                REG_SPL: spl_n = wr_data;
                REG_SPH: sph_n = wr_data;
                default: ;
            endcase
        end
        sel_err_n = !is_supported(rd_res) || (wr_en && !is_supported(wr_res));
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the file is a handful of flops rather than a RAM, so every
            // nibble is cleared; a RAM-backed file would not be reset this way.
            {a_q, b_q, xl_q, xh_q, xp_q} <= '0;
            {yl_q, yh_q, yp_q, spl_q, sph_q} <= '0;
            sel_err_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments, so every flop samples pre-edge values.
            {a_q, b_q, xl_q, xh_q, xp_q} <= {a_n, b_n, xl_n, xh_n, xp_n};
            {yl_q, yh_q, yp_q, spl_q, sph_q} <= {yl_n, yh_n, yp_n, spl_n, sph_n};
            sel_err_q <= sel_err_n;
        end
    end

    assign x_out   = {xp_q, xh_q, xl_q};
    assign y_out   = {yp_q, yh_q, yl_q};
    assign sp_out  = {sph_q, spl_q};
    assign sel_err = sel_err_q;

endmodule

// File: tb/tb_cpu_regfile.sv
// Directed vector bench for cpu_regfile (DATA_WIDTH=4, BYPASS=1).
module tb_cpu_regfile;
    import cpu_regfile_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    reg_type     rd_sel, wr_sel;
    logic [5:0]  rd_immed, wr_immed;
    logic [3:0]  rd_data, wr_data, mem_rdata, mem_wdata;
    logic        wr_en, inc_en, sp_dec, mem_we, sel_err;
    reg_inc_type inc_sel;
    logic [11:0] mem_addr, x_out, y_out;
    logic [7:0]  sp_out;

    always #5 clk = ~clk;

    cpu_regfile #(.DATA_WIDTH(4), .BYPASS(1'b1)) dut (
        .clk(clk), .reset(reset),
        .rd_sel(rd_sel), .rd_immed(rd_immed), .rd_data(rd_data),
        .wr_en(wr_en), .wr_sel(wr_sel), .wr_immed(wr_immed), .wr_data(wr_data),
        .inc_en(inc_en), .inc_sel(inc_sel), .sp_dec(sp_dec),
        .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .x_out(x_out), .y_out(y_out), .sp_out(sp_out), .sel_err(sel_err)
    );

    typedef struct {
        logic        rst;
        reg_type     rs;
        logic [5:0]  ri;
        logic [3:0]  mr;
        logic        we;
        reg_type     ws;
        logic [5:0]  wi;
        logic [3:0]  wd;
        reg_inc_type is;
        logic        dec;
        logic [3:0]  e_rd;    // x = not checked
        logic        e_mwe;
        logic [11:0] e_ma;    // x = not checked
        logic [11:0] e_x;
        logic [11:0] e_y;
        logic [7:0]  e_sp;
        logic        e_err;
    } vec_t;

    localparam int N = 35;
    vec_t tab [N];

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t v(
        input logic rst, input reg_type rs, input logic [5:0] ri, input logic [3:0] mr,
        input logic we, input reg_type ws, input logic [5:0] wi, input logic [3:0] wd,
        input reg_inc_type is, input logic dec,
        input logic [3:0] e_rd, input logic e_mwe, input logic [11:0] e_ma,
        input logic [11:0] e_x, input logic [11:0] e_y, input logic [7:0] e_sp, input logic e_err);
        vec_t r;
        r.rst = rst; r.rs = rs; r.ri = ri; r.mr = mr;
        r.we = we; r.ws = ws; r.wi = wi; r.wd = wd; r.is = is; r.dec = dec;
        r.e_rd = e_rd; r.e_mwe = e_mwe; r.e_ma = e_ma;
        r.e_x = e_x; r.e_y = e_y; r.e_sp = e_sp; r.e_err = e_err;
        return r;
    endfunction

    task automatic drive(input vec_t t);
        reset     = t.rst;
        rd_sel    = t.rs;
        rd_immed  = t.ri;
        mem_rdata = t.mr;
        wr_en     = t.we;
        wr_sel    = t.ws;
        wr_immed  = t.wi;
        wr_data   = t.wd;
        inc_en    = (t.is != REG_NONE);
        inc_sel   = t.is;
        sp_dec    = t.dec;
    endtask

    initial begin
        logic [3:0]  xd;
        logic [11:0] xa;
        vec_t idle;
        xd = 'x;
        xa = 'x;
        //            rst rs            ri         mr     we ws              wi         wd     inc       dec  e_rd   mwe e_ma     e_x      e_y      e_sp   err
        tab[0]  = v(1'b1, REG_A,        6'h00,     4'h0, 1'b0, REG_A,        6'h00,     4'h0, REG_NONE, 1'b0, xd,   1'b0, xa,     12'h000, 12'h000, 8'h00, 1'b0);
        tab[1]  = v(1'b0, REG_A,        6'h00,     4'h0, 1'b0, REG_A,        6'h00,     4'h0, REG_NONE, 1'b0, 4'h0, 1'b0, xa,     12'h000, 12'h000, 8'h00, 1'b0);
        tab[2]  = v(1'b0, REG_B,        6'h00,     4'h0, 1'b1, REG_A,        6'h00,     4'h9, REG_NONE, 1'b0, 4'h0, 1'b0, xa,     12'h000, 12'h000, 8'h00, 1'b0);
        tab[3]  = v(1'b0, REG_A,        6'h00,     4'h0, 1'b0, REG_A,        6'h00,     4'h0, REG_NONE, 1'b0, 4'h9, 1'b0, xa,     12'h000, 12'h000, 8'h00, 1'b0);
        tab[4]  = v(1'b0, REG_A,        6'h00,     4'h0, 1'b1, REG_XP,       6'h00,     4'h3, REG_NONE, 1'b0, 4'h9, 1'b0, xa,     12'h300, 12'h000, 8'h00, 1'b0);
        tab[5]  = v(1'b0, REG_A,        6'h00,     4'h0, 1'b1, REG_XH,       6'h00,     4'hF, REG_NONE, 1'b0, 4'h9, 1'b0, xa,     12'h3F0, 12'h000, 8'h00, 1'b0);
        tab[6]  = v(1'b0, REG_A,        6'h00,     4'h0, 1'b1, REG_XL,       6'h00,     4'hF, REG_NONE, 1'b0, 4'h9, 1'b0, xa,     12'h3FF, 12'h000, 8'h00, 1'b0);
        tab[7]  = v(1'b0, REG_XP,       6'h00,     4'h0, 1'b0, REG_A,        6'h00,     4'h0, REG_XHL,  1'b0, 4'h3, 1'b0, xa,     12'h300, 12'h000, 8'h00, 1'b0);
        tab[8]  = v(1'b0, REG_SPL,      6'h00,     4'h0, 1'b0, REG_A,        6'h00,     4'h0, REG_SP,   1'b1, 4'h0, 1'b0, xa,     12'h300, 12'h000, 8'hFF, 1'b0);
        tab[9]  = v(1'b0, REG_SPH,      6'h00,     4'h0, 1'b0, REG_A,        6'h00,     4'h0, REG_SP,   1'b0, 4'hF, 1'b0, xa,     12'h300, 12'h000, 8'h00, 1'b0);
        tab[10] = v(1'b0, REG_A,        6'h00,     4'h0, 1'b1, REG_YP,       6'h00,     4'h1, REG_NONE, 1'b0, 4'h9, 1'b0, xa,     12'h300, 12'h100, 8'h00, 1'b0);
        tab[11] = v(1'b0, REG_A,        6'h00,     4'h0, 1'b1, REG_YH,       6'h00,     4'h2, REG_NONE, 1'b0, 4'h9, 1'b0, xa,     12'h300, 12'h120, 8'h00, 1'b0);
        tab[12] = v(1'b0, REG_A,        6'h00,     4'h0, 1'b1, REG_YL,       6'h00,     4'h4, REG_NONE, 1'b0, 4'h9, 1'b0, xa,     12'h300, 12'h124, 8'h00, 1'b0);
        tab[13] = v(1'b0, REG_A,        6'h00,     4'h0, 1'b1, REG_IMM_ADDR_H, 6'b001100, 4'h5, REG_NONE, 1'b0, 4'h9, 1'b1, 12'h124, 12'h300, 12'h124, 8'h00, 1'b0);
        tab[14] = v(1'b0, REG_MX,       6'h00,     4'hA, 1'b0, REG_A,        6'h00,     4'h0, REG_NONE, 1'b0, 4'hA, 1'b0, 12'h300, 12'h300, 12'h124, 8'h00, 1'b0);
        tab[15] = v(1'b0, REG_A,        6'h00,     4'h0, 1'b1, REG_XL,       6'h00,     4'hF, REG_NONE, 1'b0, 4'h9, 1'b0, xa,     12'h30F, 12'h124, 8'h00, 1'b0);
        tab[16] = v(1'b0, REG_A,        6'h00,     4'h0, 1'b1, REG_XH,       6'h00,     4'h2, REG_NONE, 1'b0, 4'h9, 1'b0, xa,     12'h32F, 12'h124, 8'h00, 1'b0);
        tab[17] = v(1'b0, REG_A,        6'h00,     4'h0, 1'b1, REG_XL,       6'h00,     4'h7, REG_XHL,  1'b0, 4'h9, 1'b0, xa,     12'h337, 12'h124, 8'h00, 1'b0);
        tab[18] = v(1'b0, REG_B,        6'h00,     4'h0, 1'b1, REG_B,        6'h00,     4'hC, REG_NONE, 1'b0, 4'hC, 1'b0, xa,     12'h337, 12'h124, 8'h00, 1'b0);
        tab[19] = v(1'b0, REG_PCSL,     6'h00,     4'h0, 1'b0, REG_A,        6'h00,     4'h0, REG_NONE, 1'b0, 4'h0, 1'b0, xa,     12'h337, 12'h124, 8'h00, 1'b1);
        tab[20] = v(1'b0, REG_A,        6'h00,     4'h0, 1'b0, REG_A,        6'h00,     4'h0, REG_NONE, 1'b0, 4'h9, 1'b0, xa,     12'h337, 12'h124, 8'h00, 1'b0);
        tab[21] = v(1'b0, REG_A,        6'h00,     4'h0, 1'b1, REG_ALU,      6'h00,     4'h5, REG_NONE, 1'b0, 4'h9, 1'b0, xa,     12'h337, 12'h124, 8'h00, 1'b1);
        tab[22] = v(1'b0, REG_A,        6'h00,     4'h0, 1'b0, REG_ALU,      6'h00,     4'h5, REG_NONE, 1'b0, 4'h9, 1'b0, xa,     12'h337, 12'h124, 8'h00, 1'b0);
        tab[23] = v(1'b0, REG_IMML,     6'b100110, 4'h0, 1'b0, REG_A,        6'h00,     4'h0, REG_NONE, 1'b0, 4'h6, 1'b0, xa,     12'h337, 12'h124, 8'h00, 1'b0);
        tab[24] = v(1'b0, REG_IMMH,     6'b100110, 4'h0, 1'b0, REG_A,        6'h00,     4'h0, REG_NONE, 1'b0, 4'h2, 1'b0, xa,     12'h337, 12'h124, 8'h00, 1'b0);
        tab[25] = v(1'b0, REG_HARDCODED_1, 6'h00,  4'h0, 1'b0, REG_A,        6'h00,     4'h0, REG_NONE, 1'b0, 4'h1, 1'b0, xa,     12'h337, 12'h124, 8'h00, 1'b0);
        tab[26] = v(1'b0, REG_Mn,       6'b001011, 4'h3, 1'b0, REG_A,        6'h00,     4'h0, REG_NONE, 1'b0, 4'h3, 1'b0, 12'h00B, 12'h337, 12'h124, 8'h00, 1'b0);
        tab[27] = v(1'b0, REG_A,        6'h00,     4'h0, 1'b0, REG_A,        6'h00,     4'h0, REG_SP,   1'b1, 4'h9, 1'b0, xa,     12'h337, 12'h124, 8'hFF, 1'b0);
        tab[28] = v(1'b0, REG_MSP,      6'h00,     4'h6, 1'b0, REG_A,        6'h00,     4'h0, REG_NONE, 1'b0, 4'h6, 1'b0, 12'h0FF, 12'h337, 12'h124, 8'hFF, 1'b0);
        tab[29] = v(1'b0, REG_MY,       6'h00,     4'h2, 1'b1, REG_MX,       6'h00,     4'h4, REG_NONE, 1'b0, 4'h2, 1'b1, 12'h337, 12'h337, 12'h124, 8'hFF, 1'b0);
        tab[30] = v(1'b0, REG_A,        6'h00,     4'h0, 1'b0, REG_A,        6'h00,     4'h0, REG_YHL,  1'b0, 4'h9, 1'b0, xa,     12'h337, 12'h125, 8'hFF, 1'b0);
        tab[31] = v(1'b0, REG_IMM_ADDR_L, 6'b000001, 4'h0, 1'b0, REG_A,      6'h00,     4'h0, REG_NONE, 1'b0, 4'hC, 1'b0, xa,     12'h337, 12'h125, 8'hFF, 1'b0);
        tab[32] = v(1'b1, REG_A,        6'h00,     4'h0, 1'b1, REG_XP,       6'h00,     4'h5, REG_XHL,  1'b0, 4'h9, 1'b0, xa,     12'h000, 12'h000, 8'h00, 1'b0);
        tab[33] = v(1'b0, REG_A,        6'h00,     4'h0, 1'b0, REG_A,        6'h00,     4'h0, REG_NONE, 1'b0, 4'h0, 1'b0, xa,     12'h000, 12'h000, 8'h00, 1'b0);
        tab[34] = v(1'b0, REG_B,        6'h00,     4'h0, 1'b0, REG_A,        6'h00,     4'h0, REG_NONE, 1'b0, 4'h0, 1'b0, xa,     12'h000, 12'h000, 8'h00, 1'b0);

        idle = tab[33];
        drive(idle);
        reset = 1'b1;

        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            drive(tab[i]);
            #1;
            if (!$isunknown(tab[i].e_rd))
                check($sformatf("v%0d rd_data", i), 32'(rd_data), 32'(tab[i].e_rd));
            check($sformatf("v%0d mem_we", i), 32'(mem_we), 32'(tab[i].e_mwe));
            if (tab[i].e_mwe)
                check($sformatf("v%0d mem_wdata", i), 32'(mem_wdata), 32'(tab[i].wd));
            if (!$isunknown(tab[i].e_ma))
                check($sformatf("v%0d mem_addr", i), 32'(mem_addr), 32'(tab[i].e_ma));
            @(posedge clk);
            #1;
            check($sformatf("v%0d x_out", i), 32'(x_out), 32'(tab[i].e_x));
            check($sformatf("v%0d y_out", i), 32'(y_out), 32'(tab[i].e_y));
            check($sformatf("v%0d sp_out", i), 32'(sp_out), 32'(tab[i].e_sp));
            check($sformatf("v%0d sel_err", i), 32'(sel_err), 32'(tab[i].e_err));
        end

        // Hand sequence: Y = 0x6FF, then YHL increment wraps {YH,YL} and keeps YP.
        begin
            vec_t s;
            s = idle;
            s.we = 1'b1;
            s.ws = REG_YP; s.wd = 4'h6; @(negedge clk); drive(s);
            s.ws = REG_YH; s.wd = 4'hF; @(negedge clk); drive(s);
            s.ws = REG_YL; s.wd = 4'hF; @(negedge clk); drive(s);
            @(posedge clk); #1;
            check("seq y_preload", 32'(y_out), 32'h6FF);
            s = idle;
            s.is = REG_YHL;
            @(negedge clk); drive(s);
            @(posedge clk); #1;
            check("seq y_wrap", 32'(y_out), 32'h600);
            s = idle;
            s.rs = REG_YH;
            @(negedge clk); drive(s);
            #1;
            check("seq yh_read", 32'(rd_data), 32'h0);
            s.rs = REG_YP;
            drive(s);
            #1;
            check("seq yp_read", 32'(rd_data), 32'h6);
        end

        // Hand sequence: write to SPL while SP decrements; SPH keeps its decremented value.
        begin
            vec_t s;
            s = idle;
            s.we = 1'b1; s.ws = REG_SPL; s.wd = 4'h3;
            s.is = REG_SP; s.dec = 1'b1;
            @(negedge clk); drive(s);
            @(posedge clk); #1;
            check("seq sp_dec_write", 32'(sp_out), 32'hF3);
            s = idle;
            s.we = 1'b1; s.ws = REG_IMML; s.wd = 4'h7;
            @(negedge clk); drive(s);
            #1;
            check("seq imm_write_mem_we", 32'(mem_we), 32'h0);
            @(posedge clk); #1;
            check("seq imm_write_ignored", 32'({x_out, y_out, sp_out}), 32'({12'h000, 12'h600, 8'hF3}));
        end

        @(negedge clk);
        drive(idle);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cpu_regfile.md
# cpu_regfile

Parametrised CPU register file and index-register unit for the Tamagotchi core. It holds A, B, X (XP:XH:XL), Y (YP:YH:YL) and SP (SPH:SPL), and resolves `reg_type` selects, including the immediate-addressed r/q forms, into register reads and writes or data-memory accesses. It applies the `reg_inc_type` post-increment and SP pre-decrement. It sits between the microcode sequencer and the data-memory port, and replaces the ad-hoc register logic in the core.

## Interface
Parameters:
- `DATA_WIDTH`, default 4. Width of one register nibble.
- `BYPASS`, default 1. 1 = a read of the register being written returns `wr_data` in the same cycle; 0 = the read returns the old value.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high.
- `rd_sel`  in  `reg_type`  read source.
- `rd_immed`  in  6  immediate used to resolve `REG_IMM_ADDR_*` and `REG_Mn` on the read side.
- `rd_data`  out  DATA_WIDTH  read result (combinational).
- `wr_en`  in  1  write strobe.
- `wr_sel`  in  `reg_type`  write destination.
- `wr_immed`  in  6  immediate for the write side.
- `wr_data`  in  DATA_WIDTH  write value.
- `inc_en`  in  1  index update strobe.
- `inc_sel`  in  `reg_inc_type`  index register to update.
- `sp_dec`  in  1  when `inc_sel`=`REG_SP`: 1 = decrement SP, 0 = increment SP.
- `mem_addr`  out  3*DATA_WIDTH  data-memory address for the current memory access.
- `mem_rdata`  in  DATA_WIDTH  memory read data.
- `mem_we`  out  1  memory write strobe.
- `mem_wdata`  out  DATA_WIDTH  memory write data.
- `x_out`, `y_out`  out  3*DATA_WIDTH  current X and Y.
- `sp_out`  out  2*DATA_WIDTH  current SP.
- `sel_err`  out  1  registered pulse flagging an unsupported select.

## Operation
- Resolution: `REG_IMM_ADDR_L/H/P` map through `imm_addressed_reg` using `immed[1:0]`/`[3:2]`/`[5:4]`: 00 = A, 01 = B, 10 = MX, 11 = MY.
- Memory selects:
  - MX → `mem_addr`=X.
  - MY → `mem_addr`=Y.
  - MSP → `mem_addr`={0, SP}.
  - Mn → `mem_addr`={0, immed[3:0]}.
  - A memory read returns `mem_rdata`. A memory write drives `mem_we`=`wr_en` and `mem_wdata`=`wr_data`.
- `mem_addr` arbitration: a write memory select takes priority over a read memory select.
- Supported register selects: `REG_A`, `REG_B`, `REG_XL/XH/XP`, `REG_YL/YH/YP`, `REG_SPL/SPH`, `REG_IMML/IMMH`, `REG_HARDCODED_1`.
  - `REG_IMML` reads `rd_immed[3:0]`.
  - `REG_IMMH` reads `{rd_immed[5:4]}` zero-extended.
  - `REG_HARDCODED_1` reads 1.
  - Writes to the IMM and HARDCODED selects are ignored.
- Any other select (ALU, FLAGS, TEMP, PC*) reads 0 and ignores writes. `sel_err` goes high on the next cycle when either port uses such a select with its strobe active. A read counts as active every cycle.
- Increment:
  - `REG_XHL`: {XH,XL} += 1 mod 2^(2W). XP is never modified.
  - `REG_YHL`: same for Y.
  - `REG_SP`: SP ±1 mod 2^(2W).
  - `REG_NONE`: no update.
- Simultaneous write and increment on the same nibble: the incremented value is computed first, then the write overrides only the written nibble. The other nibble keeps its incremented value.
- The increment uses pre-write register values.

## Timing
- Reset: A, B, X, Y, SP = 0 and `sel_err`=0. `mem_we` follows its inputs combinationally (0 when `wr_en`=0).
- Register writes and increments take effect at the `clk` edge. A read sees the new value on the next cycle, or in the same cycle when BYPASS=1 and `rd_sel`=`wr_sel` (after resolution).
- Memory access is zero-latency combinational. The external memory must return `mem_rdata` in the same cycle.
- `reset` overrides write and increment in the same cycle.

## Structure
- The `types` package gains:
  - constant `NIBBLE`=4;
  - function `is_mem_reg(reg_type)`;
  - function `resolve_reg(reg_type, immed)`, which wraps `imm_addressed_reg` and passes non-IMM_ADDR types through unchanged.
- One sub-module, `index_counter`, parametrised by width. It takes {hi,lo} plus inc/dec and returns the wrapped result. It is instantiated three times, for X, Y and SP.

## Test plan
- Reset, then `rd_sel`=`REG_A` → `rd_data`=0. Write A=0x9 with `wr_en` → next cycle `rd_data`=0x9.
- X=0x3FF, `inc_en` with `REG_XHL` → X=0x300 (XP kept).
- SP=0x00, `sp_dec`=1 → SP=0xFF. Then increment → SP=0x00.
- Y=0x124, `wr_sel`=`REG_IMM_ADDR_H`, `wr_immed`=6'b001100 (MY), `wr_data`=0x5 → `mem_we`=1, `mem_addr`=0x124, `mem_wdata`=0x5, no register change.
- XL=0xF, XH=0x2 with write XL=0x7 and `REG_XHL` increment in the same cycle → XH=0x3, XL=0x7.
- With BYPASS=1, write B=0xC while reading B → `rd_data`=0xC in the same cycle. `rd_sel`=`REG_PCSL` → `rd_data`=0, and `sel_err`=1 the following cycle.
